// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions: the fixed-point multiply used by every MAC.
package tpu_pkg;

  // Widest operand the multiply supports; wider words would silently lose bits.
  localparam int unsigned FX_MAX_W  = 64;
  localparam int unsigned FX_PROD_W = 2 * FX_MAX_W;

  // Signed Qm.q multiply: full-precision product, arithmetic shift right by q.
  // No rounding: the shift floors toward minus infinity. The caller truncates
  // the result to its own word width, which gives wrap-around with no saturation.
  function automatic logic signed [FX_PROD_W-1:0] fxmul(
    input logic signed [FX_MAX_W-1:0] a,
    input logic signed [FX_MAX_W-1:0] b,
    input int unsigned                q
  );
    logic signed [FX_PROD_W-1:0] prod;
    prod = FX_PROD_W'(a) * FX_PROD_W'(b);
    return prod >>> q;
  endfunction

endpackage : tpu_pkg

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary systolic array.
// It forwards its left operand to the right and its top operand downward, and
// accumulates their fixed-point product into its local accumulator.
// Ports:
//   clk, rst       clock and asynchronous active-low reset
//   en             advance: latch operands and accumulate
//   x_left         signed operand arriving from the left neighbour or the array edge
//   y_top          signed operand arriving from the upper neighbour or the array edge
//   x_right        registered copy of x_left, for the right neighbour
//   y_bottom       registered copy of y_top, for the lower neighbour
//   acc            running accumulator (N-bit, wraps on overflow)
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int unsigned Q = 10,
  parameter int unsigned N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] x_left,
  input  logic signed [N-1:0] y_top,
  output logic signed [N-1:0] x_right,
  output logic signed [N-1:0] y_bottom,
  output logic signed [N-1:0] acc
);

  logic signed [N-1:0] r_x;
  logic signed [N-1:0] r_y;
  logic signed [N-1:0] r_acc;
  logic signed [N-1:0] w_prod;

  // The product uses the incoming operands, not the registered ones, so a
  // value is consumed on the same edge that it is captured.
  assign w_prod = N'(fxmul(FX_MAX_W'(x_left), FX_MAX_W'(y_top), Q));

  // Operand pipeline and accumulator; all of them hold while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (en) begin
      r_x   <= x_left;
      r_y   <= y_top;
      r_acc <= r_acc + w_prod;
    end
  end

  assign x_right  = r_x;
  assign y_bottom = r_y;
  assign acc      = r_acc;

endmodule : systolic_pe

// File: rtl/systolic_array.sv
// MxM output-stationary systolic array of fixed-point MAC elements.
// A rows stream in from the left and B columns stream in from the top. The
// operands must already be skewed by the upstream sequencer. PE[i][j] builds
// C[i][j] in place, and every accumulator is visible in parallel.
// Ports:
//   clk, rst       clock and asynchronous active-low reset
//   en             advance the whole grid by one step
//   x_in[i]        left operand for row i (enters PE[i][0])
//   y_in[j]        top operand for column j (enters PE[0][j])
//   x_out[i]       x register of PE[i][M-1]
//   y_out[j]       y register of PE[M-1][j]
//   acc_sum[i][j]  accumulator of PE[i][j]
module systolic_array
  import tpu_pkg::*;
#(
  parameter int unsigned Q = 10,
  parameter int unsigned N = 32,
  parameter int unsigned M = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] x_in    [M],
  input  logic signed [N-1:0] y_in    [M],
  output logic signed [N-1:0] x_out   [M],
  output logic signed [N-1:0] y_out   [M],
  output logic signed [N-1:0] acc_sum [M][M]
);

  // Registered operand of each PE, plus the operands presented to each PE.
  logic signed [N-1:0] w_x    [M][M];
  logic signed [N-1:0] w_y    [M][M];
  logic signed [N-1:0] w_left [M][M];
  logic signed [N-1:0] w_top  [M][M];

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      // Column 0 is fed from the array edge; other columns from the left PE.
      if (j == 0) begin : g_left_edge
        assign w_left[i][j] = x_in[i];
      end else begin : g_left_pe
        assign w_left[i][j] = w_x[i][j-1];
      end

      // Row 0 is fed from the array edge; other rows from the PE above.
      if (i == 0) begin : g_top_edge
        assign w_top[i][j] = y_in[j];
      end else begin : g_top_pe
        assign w_top[i][j] = w_y[i-1][j];
      end

      systolic_pe #(
        .Q (Q),
        .N (N)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .x_left   (w_left[i][j]),
        .y_top    (w_top[i][j]),
        .x_right  (w_x[i][j]),
        .y_bottom (w_y[i][j]),
        .acc      (acc_sum[i][j])
      );
    end
  end

  // Operands fall off the right and bottom edges after M enabled steps.
  for (genvar k = 0; k < M; k++) begin : g_edge_out
    assign x_out[k] = w_x[k][M-1];
    assign y_out[k] = w_y[M-1][k];
  end

endmodule : systolic_array

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array. Three arrays are built: M=1/Q=10, M=2/Q=0 and the default 6x6/Q=10.
module tb_systolic_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en1, en2, en6;

  logic signed [31:0] x1 [1], y1 [1], xo1 [1], yo1 [1], acc1 [1][1];
  logic signed [31:0] x2 [2], y2 [2], xo2 [2], yo2 [2], acc2 [2][2];
  logic signed [31:0] x6 [6], y6 [6], xo6 [6], yo6 [6], acc6 [6][6];

  int n_checks = 0;
  int n_fail   = 0;

  // Skewed 2x2 streams for A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  int xs2 [4][2];
  int ys2 [4][2];
  int exp_c2 [2][2];

  systolic_array #(.Q(10), .N(32), .M(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .x_in(x1), .y_in(y1),
    .x_out(xo1), .y_out(yo1), .acc_sum(acc1)
  );

  systolic_array #(.Q(0), .N(32), .M(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .x_in(x2), .y_in(y2),
    .x_out(xo2), .y_out(yo2), .acc_sum(acc2)
  );

  systolic_array u_dut6 (
    .clk(clk), .rst(rst), .en(en6), .x_in(x6), .y_in(y6),
    .x_out(xo6), .y_out(yo6), .acc_sum(acc6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en1 = 1'b0; en2 = 1'b0; en6 = 1'b0;
    x1[0] = '0; y1[0] = '0;
    for (int i = 0; i < 2; i++) begin x2[i] = '0; y2[i] = '0; end
    for (int i = 0; i < 6; i++) begin x6[i] = '0; y6[i] = '0; end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  // Number of nonzero outputs across all three instances.
  function automatic int nonzero_outputs();
    int n = 0;
    if (xo1[0] !== 0) n++;
    if (yo1[0] !== 0) n++;
    if (acc1[0][0] !== 0) n++;
    for (int i = 0; i < 2; i++) begin
      if (xo2[i] !== 0) n++;
      if (yo2[i] !== 0) n++;
      for (int j = 0; j < 2; j++) if (acc2[i][j] !== 0) n++;
    end
    for (int i = 0; i < 6; i++) begin
      if (xo6[i] !== 0) n++;
      if (yo6[i] !== 0) n++;
      for (int j = 0; j < 6; j++) if (acc6[i][j] !== 0) n++;
    end
    return n;
  endfunction

  // Partial sum of PE[i][j] after k enabled steps of the 2x2 stream.
  // At step u the PE sees x_in[i] from step u-j and y_in[j] from step u-i.
  function automatic int model_acc2(int k, int i, int j);
    int s = 0;
    for (int u = 0; u < k; u++) begin
      if (u - j >= 0 && u - i >= 0 && u - j < 4 && u - i < 4)
        s += xs2[u-j][i] * ys2[u-i][j];
    end
    return s;
  endfunction

  function automatic longint fx_ref(longint a, longint b);
    longint p;
    p = a * b;
    return p >>> 10;
  endfunction

  task automatic test_reset();
    int nz;
    clear_inputs();
    rst = 1'b1;
    en6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x6[i] = 32'((i + 1) * 1024);
      y6[i] = 32'((i + 2) * 1024);
    end
    tick();
    tick();
    // PE[0][0]: 1.0*2.0 accumulated twice.
    n_checks++;
    if (acc6[0][0] !== 32'sd4096) begin
      n_fail++;
      $display("FAIL pre_reset_acc: got %0d expected 4096", acc6[0][0]);
    end
    #2;
    rst = 1'b0;
    #1;
    nz = nonzero_outputs();
    n_checks++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL async_reset: %0d outputs nonzero, expected 0", nz);
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_single_pe();
    do_reset();
    en1 = 1'b1;
    x1[0] = 32'sd2048;
    y1[0] = 32'sd1536;
    tick();
    n_checks++;
    if (acc1[0][0] !== 32'sd3072) begin
      n_fail++; $display("FAIL single_acc1: got %0d expected 3072", acc1[0][0]);
    end
    n_checks++;
    if (xo1[0] !== 32'sd2048 || yo1[0] !== 32'sd1536) begin
      n_fail++; $display("FAIL single_echo: got x=%0d y=%0d expected 2048 1536", xo1[0], yo1[0]);
    end
    tick();
    n_checks++;
    if (acc1[0][0] !== 32'sd6144) begin
      n_fail++; $display("FAIL single_acc2: got %0d expected 6144", acc1[0][0]);
    end
    en1 = 1'b0;
  endtask

  task automatic test_sign();
    do_reset();
    en1 = 1'b1;
    x1[0] = -32'sd1024;
    y1[0] = 32'sd512;
    tick();
    n_checks++;
    if (acc1[0][0] !== -32'sd512) begin
      n_fail++; $display("FAIL sign_neg: got %0d expected -512", acc1[0][0]);
    end
    x1[0] = -32'sd1;
    y1[0] = 32'sd1;
    tick();
    n_checks++;
    if (acc1[0][0] !== -32'sd513) begin
      n_fail++; $display("FAIL sign_floor: got %0d expected -513", acc1[0][0]);
    end
    en1 = 1'b0;
  endtask

  task automatic test_matmul();
    int ex;
    int ey;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 2; i++) begin
        x2[i] = 32'(xs2[t][i]);
        y2[i] = 32'(ys2[t][i]);
      end
      en2 = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
        ex = (t + 1 >= 2) ? xs2[t-1][i] : 0;
        ey = (t + 1 >= 2) ? ys2[t-1][i] : 0;
        n_checks++;
        if (xo2[i] !== 32'(ex) || yo2[i] !== 32'(ey)) begin
          n_fail++;
          $display("FAIL matmul_echo step %0d lane %0d: got x=%0d y=%0d expected %0d %0d",
                   t, i, xo2[i], yo2[i], ex, ey);
        end
      end
    end
    en2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (acc2[i][j] !== 32'(exp_c2[i][j])) begin
          n_fail++;
          $display("FAIL matmul_c[%0d][%0d]: got %0d expected %0d", i, j, acc2[i][j], exp_c2[i][j]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    int ex;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 2; i++) begin
        x2[i] = 32'(xs2[t][i]);
        y2[i] = 32'(ys2[t][i]);
      end
      en2 = 1'b1;
      tick();
      en2 = 1'b0;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 2; i++) begin
          x2[i] = 32'($urandom);
          y2[i] = 32'($urandom);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (acc2[i][j] !== 32'(model_acc2(t + 1, i, j))) begin
              n_fail++;
              $display("FAIL idle_acc step %0d [%0d][%0d]: got %0d expected %0d",
                       t, i, j, acc2[i][j], model_acc2(t + 1, i, j));
            end
          end
          ex = (t >= 1) ? xs2[t-1][i] : 0;
          n_checks++;
          if (xo2[i] !== 32'(ex)) begin
            n_fail++;
            $display("FAIL idle_xout step %0d lane %0d: got %0d expected %0d", t, i, xo2[i], ex);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (acc2[i][j] !== 32'(exp_c2[i][j])) begin
          n_fail++;
          $display("FAIL gated_c[%0d][%0d]: got %0d expected %0d", i, j, acc2[i][j], exp_c2[i][j]);
        end
      end
    end
  endtask

  task automatic test_m6();
    int a [6][6];
    int b [6][6];
    logic signed [31:0] g [6][6];
    int nz;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        a[i][j] = (int'($urandom_range(14)) - 7) * 1024;
        b[i][j] = (int'($urandom_range(14)) - 7) * 1024;
      end
    end
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        g[i][j] = '0;
        for (int k = 0; k < 6; k++)
          g[i][j] = g[i][j] + 32'(fx_ref(longint'(a[i][k]), longint'(b[k][j])));
      end
    end
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 6; i++) begin
        x6[i] = (t - i >= 0 && t - i < 6) ? 32'(a[i][t-i]) : '0;
        y6[i] = (t - i >= 0 && t - i < 6) ? 32'(b[t-i][i]) : '0;
      end
      en6 = 1'b1;
      tick();
    end
    en6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        n_checks++;
        if (acc6[i][j] !== g[i][j]) begin
          n_fail++;
          $display("FAIL m6_c[%0d][%0d]: got %0d expected %0d", i, j, acc6[i][j], g[i][j]);
        end
      end
    end
    // Start a fresh run and abandon it with a reset between edges.
    do_reset();
    en6 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 6; i++) begin
        x6[i] = 32'(a[i][t]);
        y6[i] = 32'(b[t][i]) + 32'sd1024;
      end
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    nz = nonzero_outputs();
    n_checks++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL m6_midrun_reset: %0d outputs nonzero, expected 0", nz);
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  initial begin
    xs2 = '{'{1, 0}, '{2, 3}, '{0, 4}, '{0, 0}};
    ys2 = '{'{5, 0}, '{7, 6}, '{0, 8}, '{0, 0}};
    exp_c2 = '{'{19, 22}, '{43, 50}};
    clear_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();

    test_reset();
    test_single_pe();
    test_sign();
    test_matmul();
    test_enable_gating();
    test_m6();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_systolic_array
